// File: rtl/dac_jesd204_pkg.sv
// Shared definitions for the DAC JESD204 transmit framer: FSM encoding and octet geometry.
// Consumed by dac_jesd204_tx_framer and dac_jesd204_tx_map.
package dac_jesd204_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam int OCTETS_PER_SAMPLE = 2;
  localparam int OCTETS_PER_LANE   = 4;

  // Keeps the top CHANNEL_WIDTH bits of a 16-bit MSB-aligned sample.
  function automatic logic [15:0] sample_mask(input int channel_width);
    return 16'hFFFF << (16 - channel_width);
  endfunction

endpackage

// File: rtl/dac_jesd204_tx_map.sv
// Combinational octet mapper: reorders channel-grouped samples into the JESD204 octet stream.
// Output is all zeros when head_valid is low.
module dac_jesd204_tx_map
  import dac_jesd204_pkg::*;
#(
  parameter int NUM_LANES     = 1,
  parameter int NUM_CHANNELS  = 1,
  parameter int CHANNEL_WIDTH = 16
) (
  input  logic [NUM_LANES*OCTETS_PER_LANE*8-1:0] head,
  input  logic                                   head_valid,
  output logic [NUM_LANES*OCTETS_PER_LANE*8-1:0] data
);

  localparam int SW  = OCTETS_PER_SAMPLE * 8;
  localparam int DPW = 2 * NUM_LANES / NUM_CHANNELS;
  localparam logic [SW-1:0] MASK = sample_mask(CHANNEL_WIDTH);

  always_comb begin
    // NOTE: default every output first so no path through the block infers a latch.
    data = '0;
    if (head_valid) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        for (int s = 0; s < DPW; s++) begin
          // Sample index i = s*NUM_CHANNELS + c; its MSB octet goes first on the wire.
          data[(s*NUM_CHANNELS + c)*SW     +: 8] = head[(c*DPW + s)*SW + 8 +: 8] & MASK[15:8];
          data[(s*NUM_CHANNELS + c)*SW + 8 +: 8] = head[(c*DPW + s)*SW     +: 8] & MASK[7:0];
        end
      end
    end
  end

endmodule

// File: rtl/dac_jesd204_tx_framer.sv
// DAC JESD204 transmit framer: 2-entry beat FIFO, IDLE/PRIME/RUN/DRAIN control and underflow flag.
// Optional underflow counter port enabled by defining DAC_JESD204_TX_UNDERFLOW_CNT_EN.
module dac_jesd204_tx_framer
  import dac_jesd204_pkg::*;
#(
  parameter int NUM_LANES     = 1,
  parameter int NUM_CHANNELS  = 1,
  parameter int CHANNEL_WIDTH = 16
) (
  input  logic                    tx_clk,
  input  logic                    tx_rst,
  input  logic                    enable,
  input  logic                    dac_valid,
  input  logic [NUM_LANES*32-1:0] dac_data,
  output logic                    dac_ready,
  output logic                    tx_valid,
  output logic [NUM_LANES*32-1:0] tx_data,
  input  logic                    tx_ready,
  output logic                    underflow,
  input  logic                    underflow_clr
`ifdef DAC_JESD204_TX_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]             underflow_cnt
`endif
);

  localparam int DW = NUM_LANES * OCTETS_PER_LANE * 8;

  logic [1:0]    state, state_nxt;
  logic [DW-1:0] mem [2];
  logic          wr_ptr, rd_ptr;
  logic [1:0]    count;
  logic          empty, wr_en, rd_en, underflow_evt;

  assign empty         = (count == 2'd0);
  // No full bypass: a full FIFO refuses writes even while it is being read.
  assign dac_ready     = ((state == ST_PRIME) || (state == ST_RUN)) && (count < 2'd2);
  assign tx_valid      = (state == ST_PRIME) || (state == ST_RUN) || ((state == ST_DRAIN) && !empty);
  assign wr_en         = dac_valid && dac_ready;
  assign rd_en         = tx_valid && tx_ready && !empty;
  assign underflow_evt = (state == ST_RUN) && tx_ready && empty;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (enable) state_nxt = ST_PRIME;
      ST_PRIME: if (!enable) state_nxt = ST_DRAIN;
                else if (wr_en) state_nxt = ST_RUN;
      ST_RUN:   if (!enable) state_nxt = ST_DRAIN;
      ST_DRAIN: if (empty) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      state  <= ST_IDLE;
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count + {1'b0, wr_en} - {1'b0, rd_en};
      if (wr_en) wr_ptr <= ~wr_ptr;
      if (rd_en) rd_ptr <= ~rd_ptr;
    end
  end

  // NOTE: storage has no reset; count gates the head, so stale contents are never sent.
  always_ff @(posedge tx_clk) begin
    if (wr_en) mem[wr_ptr] <= dac_data;
  end

  // Set wins over clear so a coincident underflow is never lost.
  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst)             underflow <= 1'b0;
    else if (underflow_evt) underflow <= 1'b1;
    else if (underflow_clr) underflow <= 1'b0;
  end

`ifdef DAC_JESD204_TX_UNDERFLOW_CNT_EN
  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      underflow_cnt <= 16'd0;
    end else if (underflow_evt) begin
      if (underflow_clr)                   underflow_cnt <= 16'd1;
      else if (underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
    end else if (underflow_clr) begin
      underflow_cnt <= 16'd0;
    end
  end
`endif

  dac_jesd204_tx_map #(
    .NUM_LANES     (NUM_LANES),
    .NUM_CHANNELS  (NUM_CHANNELS),
    .CHANNEL_WIDTH (CHANNEL_WIDTH)
  ) u_map (
    .head       (mem[rd_ptr]),
    .head_valid (!empty),
    .data       (tx_data)
  );

endmodule

// File: tb/tb_dac_jesd204_tx_framer.sv
// Self-checking bench for dac_jesd204_tx_framer (2 lanes, 2 channels): control model plus data scoreboard.
// Counter checks are active when DAC_JESD204_TX_UNDERFLOW_CNT_EN is defined.
module tb_dac_jesd204_tx_framer;

  localparam int NL  = 2;
  localparam int NC  = 2;
  localparam int CW  = 16;
  localparam int DW  = NL * 32;
  localparam int DPW = 2 * NL / NC;

  logic          tx_clk = 1'b0;
  logic          tx_rst = 1'b1;
  logic          enable = 1'b0;
  logic          dac_valid = 1'b0;
  logic [DW-1:0] dac_data = '0;
  logic          tx_ready = 1'b0;
  logic          underflow_clr = 1'b0;
  logic          dac_ready, tx_valid, underflow;
  logic [DW-1:0] tx_data;
`ifdef DAC_JESD204_TX_UNDERFLOW_CNT_EN
  logic [15:0]   underflow_cnt;
`endif

  typedef enum int {M_IDLE, M_PRIME, M_RUN, M_DRAIN} mode_t;

  mode_t         mode = M_IDLE;
  int            occ  = 0;
  bit            uf   = 1'b0;
  int            ucnt = 0;
  logic [DW-1:0] sb_q [$];
  int            n_cmp = 0;
  int            n_err = 0;

  always #5 tx_clk = ~tx_clk;

  dac_jesd204_tx_framer #(
    .NUM_LANES     (NL),
    .NUM_CHANNELS  (NC),
    .CHANNEL_WIDTH (CW)
  ) dut (
`ifdef DAC_JESD204_TX_UNDERFLOW_CNT_EN
    .underflow_cnt (underflow_cnt),
`endif
    .tx_clk        (tx_clk),
    .tx_rst        (tx_rst),
    .enable        (enable),
    .dac_valid     (dac_valid),
    .dac_data      (dac_data),
    .dac_ready     (dac_ready),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .underflow     (underflow),
    .underflow_clr (underflow_clr)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Output octet o carries sample i=o/2 (channel i%NC, slot i/NC); even octet = sample MSB.
  function automatic logic [DW-1:0] ref_map(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    logic [15:0]   smp;
    int            i, c, s;
    r = '0;
    for (int o = 0; o < DW/8; o++) begin
      i   = o / 2;
      c   = i % NC;
      s   = i / NC;
      smp = d[(c*DPW + s)*16 +: 16];
      r[8*o +: 8] = (o % 2 == 0) ? smp[15:8] : smp[7:0];
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_beat();
    return {$urandom, $urandom};
  endfunction

  // Entered and left 1 time unit after a rising edge.
  task automatic step(input bit en, input bit dv, input bit tr, input bit clr, input logic [DW-1:0] d);
    bit exp_ready, exp_valid, acc, rd, evt;
    enable = en; dac_valid = dv; tx_ready = tr; underflow_clr = clr; dac_data = d;
    @(negedge tx_clk);
    exp_ready = (mode == M_PRIME || mode == M_RUN) && occ < 2;
    exp_valid = (mode == M_PRIME || mode == M_RUN) || (mode == M_DRAIN && occ > 0);
    check("dac_ready", DW'(dac_ready), DW'(exp_ready));
    check("tx_valid",  DW'(tx_valid),  DW'(exp_valid));
    check("underflow", DW'(underflow), DW'(uf));
`ifdef DAC_JESD204_TX_UNDERFLOW_CNT_EN
    check("underflow_cnt", DW'(underflow_cnt), DW'(ucnt));
`endif
    acc = dv && exp_ready;
    rd  = exp_valid && tr && occ > 0;
    evt = (mode == M_RUN) && tr && occ == 0;
    @(posedge tx_clk);
    if (acc) sb_q.push_back(ref_map(d));
    case (mode)
      M_IDLE:  if (en) mode = M_PRIME;
      M_PRIME: if (!en) mode = M_DRAIN; else if (acc) mode = M_RUN;
      M_RUN:   if (!en) mode = M_DRAIN;
      M_DRAIN: if (occ == 0) mode = M_IDLE;
      default: mode = M_IDLE;
    endcase
    occ = occ + int'(acc) - int'(rd);
    if (evt) begin
      uf   = 1'b1;
      ucnt = clr ? 1 : (ucnt < 65535 ? ucnt + 1 : ucnt);
    end else if (clr) begin
      uf   = 1'b0;
      ucnt = 0;
    end
    #1;
  endtask

  task automatic pulse_reset();
    tx_rst = 1'b1;
    #1;
    check("rst_tx_valid",  DW'(tx_valid),  '0);
    check("rst_dac_ready", DW'(dac_ready), '0);
    check("rst_tx_data",   tx_data,        '0);
    check("rst_underflow", DW'(underflow), '0);
`ifdef DAC_JESD204_TX_UNDERFLOW_CNT_EN
    check("rst_underflow_cnt", DW'(underflow_cnt), '0);
`endif
    sb_q.delete();
    mode = M_IDLE; occ = 0; uf = 1'b0; ucnt = 0;
    @(posedge tx_clk);
    #1;
    tx_rst = 1'b0;
  endtask

  // Data monitor: head of the scoreboard (or zeros when nothing is queued) must be on tx_data.
  initial begin
    logic [DW-1:0] exp;
    forever begin
      @(negedge tx_clk);
      exp = (sb_q.size() > 0) ? sb_q[0] : '0;
      check("tx_data", tx_data, exp);
      if (tx_valid && tx_ready && sb_q.size() > 0) void'(sb_q.pop_front());
    end
  end

  initial begin
    repeat (2) @(posedge tx_clk);
    #1;
    pulse_reset();

    // Single mapped beat through PRIME.
    step(1, 0, 1, 0, '0);
    step(1, 0, 1, 0, '0);
    step(1, 1, 1, 0, 64'h4444_3333_2222_1111);
    check("map_octets", tx_data, 64'h4444_2222_3333_1111);
    step(1, 0, 1, 0, '0);

    // Three underflow beats in RUN.
    repeat (3) step(1, 0, 1, 0, '0);
    check("uf_after_3", DW'(underflow), DW'(1));
`ifdef DAC_JESD204_TX_UNDERFLOW_CNT_EN
    check("uf_cnt_3", DW'(underflow_cnt), DW'(3));
`endif

    // Underflow event coincident with clear.
    step(1, 0, 1, 1, '0);
    check("uf_set_wins", DW'(underflow), DW'(1));
`ifdef DAC_JESD204_TX_UNDERFLOW_CNT_EN
    check("uf_cnt_1", DW'(underflow_cnt), DW'(1));
`endif
    step(1, 0, 0, 1, '0);
    check("uf_cleared", DW'(underflow), DW'(0));

    // Back-pressure: fill, refuse, then drain in order.
    repeat (3) step(1, 1, 0, 0, rand_beat());
    step(1, 1, 1, 0, rand_beat());
    step(1, 1, 1, 0, rand_beat());
    step(1, 1, 0, 0, rand_beat());

    // Enable drop with two beats queued.
    repeat (4) step(0, 0, 1, 0, '0);
    check("drain_idle_valid", DW'(tx_valid), DW'(0));

    // Reset with a full FIFO, then restart through PRIME.
    step(1, 0, 0, 0, '0);
    repeat (3) step(1, 1, 0, 0, rand_beat());
    pulse_reset();
    step(1, 0, 1, 0, '0);
    repeat (3) step(1, 0, 1, 0, '0);
    check("prime_no_uf", DW'(underflow), DW'(0));

    // Randomised traffic.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 499) == 0) pulse_reset();
      step($urandom_range(0, 31) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, rand_beat());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
